serial_subtractor_8bit: RTL and testbench



---
 rtl/serial_subtractor_8bit.sv | 158 +++++++++++++++
 tb/tb_serial_subtractor_8bit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: d = a - b - b_in, one bit per clock, LSB first.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SUB_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] sd_q, sd_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             x;
    logic [WIDTH-1:0] shifted;

`ifdef SUB_OVF_EN
    logic [1:0] msb_q, msb_d;
    logic       ovf_q, ovf_d;
`endif

    assign x = sa_q[0] ^ sb_q[0] ^ br_q;
    // sd holds the upper WIDTH-1 bits seen so far; x completes the word.
    assign shifted = {x, sd_q};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SUB_OVF_EN
        msb_d    = msb_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = b_in;
                    cnt_d   = '0;
                    sd_d    = '0;
`ifdef SUB_OVF_EN
                    msb_d   = {a[WIDTH-1], b[WIDTH-1]};
`endif
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = (~sa_q[0] & sb_q[0])
                      | (~(sa_q[0] ^ sb_q[0]) & br_q);
                sd_d  = shifted[WIDTH-1:1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    d_d      = shifted;
                    borrow_d = br_d;
                    done_d   = 1'b1;
`ifdef SUB_OVF_EN
                    ovf_d    = (msb_q[1] ^ msb_q[0])
                             & (x ^ msb_q[1]);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SUB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            msb_q <= msb_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign d      = d_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed bench for serial_subtractor_8bit (ovf checks with SUB_OVF_EN).
module tb_serial_subtractor_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       borrow;
`ifdef SUB_OVF_EN
    logic       ovf;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0] prev_d   = 8'h00;
    logic       prev_br  = 1'b0;
    logic       prev_ovf = 1'b0;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .d      (d),
`ifdef SUB_OVF_EN
        .borrow (borrow),
        .ovf    (ovf)
`else
        .borrow (borrow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic do_op(input logic [7:0] ia,
                         input logic [7:0] ib,
                         input logic       ibin,
                         input logic [7:0] ed,
                         input logic       ebr,
                         input logic       eovf,
                         input bit         inj);
        int dones = 0;
        @(negedge clk);
        a = ia; b = ib; b_in = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'hA5; b = 8'h5A; b_in = ~ibin;
        check("accept", {busy, done}, {1'b1, 1'b0});
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            dones += int'(done);
            check("run", {busy, done, borrow, d},
                  {1'b1, 1'b0, prev_br, prev_d});
`ifdef SUB_OVF_EN
            check("run_ovf", ovf, prev_ovf);
`endif
            if (inj && i == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h22; b_in = 1'b1;
            end
            if (inj && i == 4) start = 1'b0;
        end
        @(posedge clk); #1;
        dones += int'(done);
        check("done_hi", {busy, done}, {1'b1, 1'b1});
        check("d", d, ed);
        check("borrow", borrow, ebr);
`ifdef SUB_OVF_EN
        check("ovf", ovf, eovf);
`endif
        if (inj) begin
            start = 1'b1; a = 8'h33; b = 8'h44; b_in = 1'b0;
        end
        @(posedge clk); #1;
        dones += int'(done);
        start = 1'b0;
        check("idle", {busy, done}, {1'b0, 1'b0});
        check("hold", {borrow, d}, {ebr, ed});
        repeat (3) begin
            @(posedge clk); #1;
            dones += int'(done);
        end
        check("one_done", dones, 1);
        check("stay_idle", {busy, d}, {1'b0, ed});
        prev_d = ed; prev_br = ebr; prev_ovf = eovf;
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0;
        a = '0; b = '0; b_in = 1'b0;
        #12;
        check("rst_out", {busy, done, borrow, d}, 11'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        do_op(8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        do_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);

        // Abort mid-run: nothing may complete, everything clears at once.
        @(negedge clk);
        a = 8'hC3; b = 8'h11; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out", {busy, done, borrow, d}, 11'd0);
`ifdef SUB_OVF_EN
        check("arst_ovf", ovf, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        check("no_done", seen, 0);
        prev_d = 8'h00; prev_br = 1'b0; prev_ovf = 1'b0;
        do_op(8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
